bank_xbar_resp_rob: RTL and testbench
=====================================

# bank_xbar_resp_rob

Crossbar-side receiver for the bank SRAM-controller read-response stream (sc_xbar_*), replacing the counter-based stand-in at the bank boundary. Responses arrive out of order, tagged with channel id and ROB slot number. They are stored per channel in an 8-entry reorder buffer and drained in slot order to each channel's consumer. Each drained entry returns one credit pulse to the bank ISU.

## Interface
Parameters:
- CH_NUM, 3, number of response channels (ids 0..2; id 3 is illegal).
- ROB_DEPTH, 8, slots per channel; rob_num width is log2(ROB_DEPTH).
- DATA_W, 128, response data width.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- sc_xbar_valid_i  in  1  response valid from SRAM controller.
- sc_xbar_ready_o  out  1  response accepted this cycle.
- sc_xbar_channel_id_i  in  2  destination channel.
- sc_xbar_rob_num_i  in  3  ROB slot within the channel.
- sc_xbar_data_i  in  DATA_W  response data.
- chN_rsp_valid_o  out  1  (N = 0..2) head-of-ROB data available for channel N.
- chN_rsp_ready_i  in  1  channel N consumer accepts.
- chN_rsp_data_o  out  DATA_W  channel N head data.
- xbar_isu_chN_credit_o  out  1  one-cycle pulse per entry drained from channel N.
- err_o  out  1  sticky: illegal channel id received.

## Operation
- Per channel: valid[7:0], data[7:0][DATA_W], head pointer (3 bit).
- Accept: sc_xbar_ready_o = !valid[ch][rob] when ch < 3; = 1 when ch == 3. This is a combinational function of the channel_id and rob_num inputs; it does not depend on valid_i. Transfer occurs when valid_i && ready_o.
- A transfer to a legal channel sets valid[ch][rob] and writes the data.
- A transfer with ch == 3 is dropped and sets err_o. err_o clears only on reset.
- Occupied slot: ready_o stays low (stall) until that slot drains. The upstream block must hold its inputs stable while stalled.
- Drain, channel N:
  - chN_rsp_valid_o = valid[N][head]; chN_rsp_data_o = data[N][head].
  - On valid && ready: clear valid[N][head], increment head modulo 8 (7 wraps to 0), and pulse xbar_isu_chN_credit_o in the following cycle (registered).
- Simultaneous events:
  - An arrival into a slot being drained in the same cycle cannot happen, because ready_o is low for an occupied slot.
  - Arrivals to non-head slots and a drain of the head in the same cycle both take effect.
  - Drains on all three channels can occur in the same cycle, so up to three credit pulses can fire at once.
- Reset:
  - Clears all valid bits, heads to 0, err_o to 0, and all credit outputs.
  - Data storage is not reset.
  - A reset asserted mid-stream discards all buffered entries; no credits are issued for them.
- Reset values: sc_xbar_ready_o follows its combinational rule (1 after reset); chN_rsp_valid_o = 0; chN_rsp_data_o is undefined; xbar_isu_chN_credit_o = 0; err_o = 0.

## Timing
- Store-to-output latency: an arrival at the head slot in cycle T is visible on chN_rsp_valid_o in cycle T+1.
- Throughput: one arrival per cycle in, and one drain per channel per cycle out.
- A credit pulse is asserted in cycle T+1 for a drain handshake in cycle T, and lasts exactly one cycle.
- A head stalled by an empty slot blocks later filled slots, which stay buffered.

## Configuration
- Macro BANK_XBAR_ROB_BYPASS_EN.
- Defined:
  - If an arriving response targets a channel's head slot while that slot is empty, it is presented combinationally on chN_rsp_valid_o and data in the same cycle.
  - If chN_rsp_ready_i is also high, the entry is consumed without being stored: head increments and the credit is pulsed at T+1.
  - If ready is low, the entry is stored as normal.
  - Latency is 0 cycles.
- Undefined: no bypass; latency is 1 cycle. All other behaviour is identical.

## Structure
- Package bank_xbar_pkg holds:
  - CH_NUM, ROB_DEPTH, DATA_W.
  - ROB_IDX_W = 3.
  - Channel-id constants CH0/CH1/CH2/CH_ILLEGAL = 2'd3.
- Sub-module bank_xbar_rob_chan is instantiated once per channel. It contains:
  - the 8-entry storage, head pointer, drain handshake, credit register and optional bypass;
  - a write port (wr_en, wr_idx, wr_data) and a slot_busy query (query_idx -> busy).
- The top level decodes channel_id, selects slot_busy from the addressed channel to form ready_o, and holds err_o.

## Test plan
- In-order fill: ch0 rob 0..7 one per cycle, ch0_rsp_ready_i = 1 -> eight drains in order. Credit pulses occur in cycles 2..9, with data matching.
- Out-of-order: ch1 receives rob 3, 1, 2, then 0 -> ch1_rsp_valid_o stays low until rob 0 arrives. Then rob 0, 1, 2, 3 drain on consecutive cycles, giving four credits.
- Collision stall: ch2 rob 5 filled, head = 0 held with ready = 0, then a second ch2 rob 5 arrives -> ready_o = 0 until slot 5 drains, then it is accepted.
- Wrap: 20 responses through ch0 in order -> head wraps 7->0 twice with no loss. Total of 20 credits.
- Illegal id: channel_id = 3 with valid -> accepted (ready = 1), no channel output, err_o = 1 and sticky. rst_i clears it.
- Reset mid-stream: ch0 holds 4 entries, assert rst_i for 1 cycle -> all valids = 0 and no credits. A new rob 0 then drains normally. With BANK_XBAR_ROB_BYPASS_EN defined, this rob 0 appears on ch0_rsp_valid_o in the same cycle it arrives.

Source files
------------

// File: rtl/bank_xbar_pkg.sv
// Shared sizing and channel-id encoding for the bank crossbar response reorder buffer.
package bank_xbar_pkg;
   localparam int CH_NUM    = 3;
   localparam int ROB_DEPTH = 8;
   localparam int DATA_W    = 128;
   localparam int ROB_IDX_W = 3;

   typedef logic [1:0] ch_id_t;

   localparam ch_id_t CH0        = 2'd0;
   localparam ch_id_t CH1        = 2'd1;
   localparam ch_id_t CH2        = 2'd2;
   localparam ch_id_t CH_ILLEGAL = 2'd3;
endpackage

// File: rtl/bank_xbar_rob_chan.sv
// One channel's reorder buffer: slots drain in order from head, one credit pulse the cycle after each drain.
// Latency 1 cycle; with BANK_XBAR_ROB_BYPASS_EN an arrival at an empty head is presented in the same cycle.
module bank_xbar_rob_chan
   import bank_xbar_pkg::*;
#(
   parameter int ROB_DEPTH = bank_xbar_pkg::ROB_DEPTH,
   parameter int DATA_W    = bank_xbar_pkg::DATA_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_en,
   input  logic [ROB_IDX_W-1:0] wr_idx,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [ROB_IDX_W-1:0] query_idx,
   output logic                 busy,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_W-1:0]    rsp_data,
   output logic                 credit
);
   logic [ROB_DEPTH-1:0] valid_q;
   logic [DATA_W-1:0]    data_q [ROB_DEPTH];
   logic [ROB_IDX_W-1:0] head_q;
   logic                 drain;
   logic                 store;

   assign busy = valid_q[query_idx];

`ifdef BANK_XBAR_ROB_BYPASS_EN
   logic bypass;
   // Only an empty head slot can be bypassed; an occupied one already stalls the writer.
   assign bypass    = wr_en && (wr_idx == head_q) && !valid_q[head_q];
   assign rsp_valid = valid_q[head_q] || bypass;
   assign rsp_data  = bypass ? wr_data : data_q[head_q];
   assign store     = wr_en && !(bypass && rsp_ready);
`else
   assign rsp_valid = valid_q[head_q];
   assign rsp_data  = data_q[head_q];
   assign store     = wr_en;
`endif

   assign drain = rsp_valid && rsp_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         head_q  <= '0;
         credit  <= 1'b0;
      end else begin
         credit <= drain;
         if (drain) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + ROB_IDX_W'(1);
         end
         if (store)
            valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (store)
         data_q[wr_idx] <= wr_data;
   end
endmodule

// File: rtl/bank_xbar_resp_rob.sv
// Crossbar receiver for out-of-order SRAM-controller read responses, reordered per channel, one credit per drain.
// ready_o drops while the addressed slot is occupied; id 3 is swallowed and sets sticky err_o. Macro: BANK_XBAR_ROB_BYPASS_EN.
module bank_xbar_resp_rob
   import bank_xbar_pkg::*;
#(
   parameter int CH_NUM    = bank_xbar_pkg::CH_NUM,
   parameter int ROB_DEPTH = bank_xbar_pkg::ROB_DEPTH,
   parameter int DATA_W    = bank_xbar_pkg::DATA_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 sc_xbar_valid_i,
   output logic                 sc_xbar_ready_o,
   input  logic [1:0]           sc_xbar_channel_id_i,
   input  logic [ROB_IDX_W-1:0] sc_xbar_rob_num_i,
   input  logic [DATA_W-1:0]    sc_xbar_data_i,
   output logic                 ch0_rsp_valid_o,
   input  logic                 ch0_rsp_ready_i,
   output logic [DATA_W-1:0]    ch0_rsp_data_o,
   output logic                 ch1_rsp_valid_o,
   input  logic                 ch1_rsp_ready_i,
   output logic [DATA_W-1:0]    ch1_rsp_data_o,
   output logic                 ch2_rsp_valid_o,
   input  logic                 ch2_rsp_ready_i,
   output logic [DATA_W-1:0]    ch2_rsp_data_o,
   output logic                 xbar_isu_ch0_credit_o,
   output logic                 xbar_isu_ch1_credit_o,
   output logic                 xbar_isu_ch2_credit_o,
   output logic                 err_o
);
   logic [CH_NUM-1:0] busy;
   logic [CH_NUM-1:0] wr_en;
   logic [CH_NUM-1:0] rsp_valid;
   logic [CH_NUM-1:0] rsp_ready;
   logic [CH_NUM-1:0] credit;
   logic [DATA_W-1:0] rsp_data [CH_NUM];
   logic              slot_busy;
   logic              accept;
   logic              err_q;

   always_comb begin
      slot_busy = 1'b0;
      case (sc_xbar_channel_id_i)
         CH0:     slot_busy = busy[0];
         CH1:     slot_busy = busy[1];
         CH2:     slot_busy = busy[2];
         default: slot_busy = 1'b0;
      endcase
   end

   // Illegal ids are always accepted so a bad sender cannot wedge the stream.
   assign sc_xbar_ready_o = (sc_xbar_channel_id_i == CH_ILLEGAL) || !slot_busy;
   assign accept          = sc_xbar_valid_i && sc_xbar_ready_o;

   assign rsp_ready = {ch2_rsp_ready_i, ch1_rsp_ready_i, ch0_rsp_ready_i};

   for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
      assign wr_en[g] = accept && (sc_xbar_channel_id_i == ch_id_t'(g));

      bank_xbar_rob_chan #(
         .ROB_DEPTH (ROB_DEPTH),
         .DATA_W    (DATA_W)
      ) u_chan (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .wr_en     (wr_en[g]),
         .wr_idx    (sc_xbar_rob_num_i),
         .wr_data   (sc_xbar_data_i),
         .query_idx (sc_xbar_rob_num_i),
         .busy      (busy[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_data  (rsp_data[g]),
         .credit    (credit[g])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         err_q <= 1'b0;
      else if (accept && (sc_xbar_channel_id_i == CH_ILLEGAL))
         err_q <= 1'b1;
   end

   assign err_o                 = err_q;
   assign ch0_rsp_valid_o       = rsp_valid[0];
   assign ch1_rsp_valid_o       = rsp_valid[1];
   assign ch2_rsp_valid_o       = rsp_valid[2];
   assign ch0_rsp_data_o        = rsp_data[0];
   assign ch1_rsp_data_o        = rsp_data[1];
   assign ch2_rsp_data_o        = rsp_data[2];
   assign xbar_isu_ch0_credit_o = credit[0];
   assign xbar_isu_ch1_credit_o = credit[1];
   assign xbar_isu_ch2_credit_o = credit[2];
endmodule

// File: tb/tb_bank_xbar_resp_rob.sv
// Directed bench for bank_xbar_resp_rob: per-slot expected-data queues, drain/credit monitor on the falling edge.
module tb_bank_xbar_resp_rob;
`ifdef BANK_XBAR_ROB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_i;
   logic         sc_valid;
   logic         sc_ready;
   logic [1:0]   sc_ch;
   logic [2:0]   sc_rob;
   logic [127:0] sc_data;
   logic [2:0]   vld;
   logic [2:0]   rdy;
   logic [2:0]   cred;
   logic [127:0] dat [3];
   logic         err;

   int checks   = 0;
   int failures = 0;

   logic [127:0] exp_q [24][$];
   int           mh [3];
   int           drain_cnt [3];
   int           cred_cnt [3];
   logic [2:0]   exp_cred = 3'b000;

   always #5 clk = ~clk;

   bank_xbar_resp_rob dut (
      .clk_i                 (clk),
      .rst_i                 (rst_i),
      .sc_xbar_valid_i       (sc_valid),
      .sc_xbar_ready_o       (sc_ready),
      .sc_xbar_channel_id_i  (sc_ch),
      .sc_xbar_rob_num_i     (sc_rob),
      .sc_xbar_data_i        (sc_data),
      .ch0_rsp_valid_o       (vld[0]),
      .ch0_rsp_ready_i       (rdy[0]),
      .ch0_rsp_data_o        (dat[0]),
      .ch1_rsp_valid_o       (vld[1]),
      .ch1_rsp_ready_i       (rdy[1]),
      .ch1_rsp_data_o        (dat[1]),
      .ch2_rsp_valid_o       (vld[2]),
      .ch2_rsp_ready_i       (rdy[2]),
      .ch2_rsp_data_o        (dat[2]),
      .xbar_isu_ch0_credit_o (cred[0]),
      .xbar_isu_ch1_credit_o (cred[1]),
      .xbar_isu_ch2_credit_o (cred[2]),
      .err_o                 (err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic int pending();
      int s = 0;
      foreach (exp_q[i]) s += exp_q[i].size();
      return s;
   endfunction

   // Monitor: credit timing every cycle, drained data popped from the slot the model head points at.
   always @(negedge clk) begin
      for (int n = 0; n < 3; n++) begin
         logic drained;
         drained = 1'b0;
         check($sformatf("credit_ch%0d", n), cred[n], exp_cred[n]);
         if (cred[n] === 1'b1) cred_cnt[n]++;
         if (rst_i) begin
            mh[n] = 0;
         end else if (vld[n] === 1'b1 && rdy[n] === 1'b1) begin
            if (exp_q[n*8 + mh[n]].size() == 0) begin
               check($sformatf("unexpected_drain_ch%0d", n), vld[n], 1'b0);
            end else begin
               check($sformatf("drain_data_ch%0d_slot%0d", n, mh[n]), dat[n], exp_q[n*8 + mh[n]].pop_front());
            end
            mh[n] = (mh[n] + 1) % 8;
            drain_cnt[n]++;
            drained = 1'b1;
         end
         exp_cred[n] = drained;
      end
      if (rst_i) foreach (exp_q[i]) exp_q[i].delete();
   end

   // Called and returns one time unit after a rising edge.
   task automatic send(input logic [1:0] ch, input logic [2:0] rob, input logic [127:0] d);
      int n = 0;
      if (ch != 2'd3) exp_q[int'(ch)*8 + int'(rob)].push_back(d);
      sc_valid = 1'b1; sc_ch = ch; sc_rob = rob; sc_data = d;
      @(negedge clk);
      while (sc_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) check("send_timeout", sc_ready, 1'b1);
      @(posedge clk); #1;
      sc_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      int left;
      left = pending();
      while (left > 0 && n < 300) begin
         @(negedge clk);
         n++;
         left = pending();
      end
      if (left != 0) check("drain_timeout", 128'(left), 128'd0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
   endtask

   initial begin
      logic [127:0] d [4];
      int c0;
      int dr;
      rst_i = 1'b1; sc_valid = 1'b0; sc_ch = 2'd0; sc_rob = 3'd0; sc_data = '0; rdy = 3'b000;
      foreach (mh[i]) begin mh[i] = 0; drain_cnt[i] = 0; cred_cnt[i] = 0; end
      repeat (2) @(posedge clk); #1;
      rst_i = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_ready", sc_ready, 1'b1);
      check("rst_valids", vld, 3'b000);
      check("rst_err", err, 1'b0);
      @(posedge clk); #1;

      // In-order fill of channel 0
      rdy[0] = 1'b1;
      c0 = cred_cnt[0];
      for (int r = 0; r < 8; r++) send(2'd0, 3'(r), rnd());
      wait_drain();
      check("inorder_credits", 128'(cred_cnt[0] - c0), 128'd8);

      // Out-of-order arrivals on channel 1: head waits for slot 0
      rdy[1] = 1'b1;
      c0 = cred_cnt[1];
      dr = drain_cnt[1];
      send(2'd1, 3'd3, rnd()); @(negedge clk); check("ooo_hold_after3", vld[1], 1'b0); @(posedge clk); #1;
      send(2'd1, 3'd1, rnd()); @(negedge clk); check("ooo_hold_after1", vld[1], 1'b0); @(posedge clk); #1;
      send(2'd1, 3'd2, rnd()); @(negedge clk); check("ooo_hold_after2", vld[1], 1'b0); @(posedge clk); #1;
      send(2'd1, 3'd0, rnd());
      // Slots 0..3 drain back to back; the bypass build already consumed slot 0
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("ooo_burst_%0d", i), vld[1], (i < (BYP ? 3 : 4)) ? 1'b1 : 1'b0);
      end
      @(posedge clk); #1;
      wait_drain();
      check("ooo_drains", 128'(drain_cnt[1] - dr), 128'd4);
      check("ooo_credits", 128'(cred_cnt[1] - c0), 128'd4);

      // Collision on channel 2 slot 5 with head parked at 5
      rdy[2] = 1'b1;
      for (int r = 0; r < 5; r++) send(2'd2, 3'(r), rnd());
      wait_drain();
      rdy[2] = 1'b0;
      c0 = cred_cnt[2];
      send(2'd2, 3'd5, rnd());
      fork
         send(2'd2, 3'd5, rnd());
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check($sformatf("collide_stall_%0d", i), sc_ready, 1'b0);
            end
            @(posedge clk); #1;
            rdy[2] = 1'b1;
         end
      join
      @(negedge clk);
      check("collide_second_buffered", vld[2], 1'b0);
      @(posedge clk); #1;
      for (int r = 6; r < 13; r++) send(2'd2, 3'(r % 8), rnd());
      wait_drain();
      check("collide_credits", 128'(cred_cnt[2] - c0), 128'd9);

      // Wrap: 20 in-order responses through channel 0
      c0 = cred_cnt[0];
      for (int i = 0; i < 20; i++) send(2'd0, 3'(i % 8), rnd());
      wait_drain();
      check("wrap_credits", 128'(cred_cnt[0] - c0), 128'd20);

      // Illegal channel id
      dr = drain_cnt[0] + drain_cnt[1] + drain_cnt[2];
      sc_valid = 1'b1; sc_ch = 2'd3; sc_rob = 3'd5; sc_data = rnd();
      @(negedge clk);
      check("illegal_ready", sc_ready, 1'b1);
      @(posedge clk); #1;
      sc_valid = 1'b0;
      @(negedge clk);
      check("illegal_err_set", err, 1'b1);
      check("illegal_no_output", vld, 3'b000);
      repeat (5) @(posedge clk); #1;
      @(negedge clk);
      check("illegal_err_sticky", err, 1'b1);
      check("illegal_no_drain", 128'(drain_cnt[0] + drain_cnt[1] + drain_cnt[2] - dr), 128'd0);
      @(posedge clk); #1;
      pulse_reset();
      @(negedge clk);
      check("illegal_err_cleared", err, 1'b0);
      @(posedge clk); #1;

      // Reset mid-stream discards buffered entries
      rdy[0] = 1'b0;
      for (int r = 0; r < 4; r++) begin d[r] = rnd(); send(2'd0, 3'(r), d[r]); end
      @(negedge clk);
      check("mid_head_valid", vld[0], 1'b1);
      check("mid_head_data", dat[0], d[0]);
      @(posedge clk); #1;
      c0 = cred_cnt[0];
      pulse_reset();
      @(negedge clk);
      check("mid_valids_cleared", vld, 3'b000);
      @(posedge clk); #1;
      d[0] = rnd();
      exp_q[0].push_back(d[0]);
      sc_valid = 1'b1; sc_ch = 2'd0; sc_rob = 3'd0; sc_data = d[0];
      @(negedge clk);
      check("post_rst_ready", sc_ready, 1'b1);
      check("post_rst_same_cycle_valid", vld[0], BYP);
      if (BYP) check("post_rst_bypass_data", dat[0], d[0]);
      @(posedge clk); #1;
      sc_valid = 1'b0;
      @(negedge clk);
      check("post_rst_next_cycle_valid", vld[0], 1'b1);
      check("post_rst_data", dat[0], d[0]);
      @(posedge clk); #1;
      rdy[0] = 1'b1;
      wait_drain();
      check("post_rst_credits", 128'(cred_cnt[0] - c0), 128'd1);
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
